crack_job_scheduler: RTL
========================

Name: crack_job_scheduler

Overview:
- Work dispatcher for a pool of NUM_ENGINES password_cracker engines.
- Splits the first-character search space (indices 0..CHARSET-1) into chunks of CHUNK indices, hands each free engine a from/to range, and collects done/found reports.
- On the first hit, it latches the cracked password and aborts all engines. If every chunk finishes with no hit, it reports exhaustion.
- Sits between the top-level cracker wrapper and the engine instances. It replaces hard-wired from/to constants.

Parameters:
- NUM_ENGINES, 4, number of engines managed (1..8)
- CHARSET, 36, size of the first-character index space
- CHUNK, 4, indices per dispatched range (1..CHARSET)
- PW_W, 32, password width in bits (4 chars x 8)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a job; ignored unless state is IDLE or DONE
- password_to_crack  in  PW_W  target; latched on accepted start
- target_pw  out  PW_W  latched target, broadcast to engines
- eng_start  out  NUM_ENGINES  one-cycle per-engine load strobe
- eng_from  out  6*NUM_ENGINES  per-engine range start; valid with eng_start and held until the next load
- eng_to  out  6*NUM_ENGINES  per-engine range end, inclusive
- eng_kill  out  1  one-cycle abort broadcast
- eng_done  in  NUM_ENGINES  per-engine one-cycle range-complete pulse
- eng_found  in  NUM_ENGINES  qualifies eng_done: hit within range
- eng_result  in  PW_W*NUM_ENGINES  per-engine matched password; valid with eng_done & eng_found
- busy  out  1  job in progress
- found  out  1  job ended with a hit
- done  out  1  job ended, hit or exhausted
- cracked_pw  out  PW_W  winning password; valid when found
- chunks_issued  out  6  count of ranges dispatched this job

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE
  - all outputs 0, including eng_from/eng_to
  - next_from=0
  - engine idle mask all ones
- States: IDLE, RUN, KILL, DONE.
- IDLE/DONE + start:
  - latch password_to_crack into target_pw
  - clear found, done, cracked_pw, chunks_issued; next_from=0
  - busy=1; go to RUN
- RUN dispatch:
  - At most one engine per cycle: the lowest-index idle engine, if next_from < CHARSET.
  - Drive eng_start[i]=1, eng_from[i]=next_from, eng_to[i]=min(next_from+CHUNK-1, CHARSET-1).
  - Mark engine i busy; next_from += CHUNK (7-bit internal arithmetic, no wrap); chunks_issued++.
  - First dispatch occurs in the cycle after the accepted start.
- RUN completion:
  - eng_done[j]=1 marks engine j idle at the next edge.
  - An engine whose eng_done arrives in the same cycle it is chosen is not re-dispatched that cycle. Idle-mask updates take effect next cycle.
- RUN hit:
  - Any eng_done[j]&eng_found[j] wins; on multiple simultaneous hits, the lowest j wins.
  - Latch cracked_pw=eng_result[j], found=1.
  - No dispatch that cycle, even if a free engine exists.
  - Go to KILL.
- KILL:
  - eng_kill=1 for exactly one cycle; all engines marked idle.
  - Go to DONE: done=1, busy=0.
- RUN exhaustion:
  - Condition: next_from >= CHARSET, all engines idle, and no hit.
  - Go to DONE with found=0, done=1, busy=0. No eng_kill.
- Ignored inputs:
  - eng_done/eng_found from an engine not marked busy are ignored.
  - eng_found without eng_done is ignored.
- DONE holds found, done and cracked_pw until the next accepted start.
- start during RUN or KILL is ignored; the job is unaffected.
- Partial last chunk: when CHARSET is not a multiple of CHUNK, the last range is clipped to CHARSET-1.
- rst asserted mid-job returns to reset values immediately. No eng_kill is issued; engines share rst.

Test Plan:
1. Defaults, no hit:
   - Stimulus: start; engines answer each range with eng_done after 10 cycles, found=0.
   - Response: ranges 0-3, 4-7, ..., 32-35 are each issued exactly once. chunks_issued=9. done=1, found=0, eng_kill never asserted.
2. Hit in a mid-job chunk:
   - Stimulus: engine 2 reports found with eng_result=32'h61626364 for range 8-11.
   - Response: cracked_pw=32'h61626364, found=1. One eng_kill pulse. No further eng_start. done=1 one cycle after the kill.
3. Simultaneous hits:
   - Stimulus: engines 1 and 3 raise eng_done&eng_found in the same cycle, results A and B.
   - Response: cracked_pw=A (lowest index wins).
4. Clipped last chunk:
   - Stimulus: CHARSET=10, CHUNK=4.
   - Response: ranges issued are 0-3, 4-7, 8-9.
5. Dispatch ordering:
   - Stimulus: start pulsed during RUN; all engines free on first dispatch.
   - Response: the start is ignored. Engines 0, 1, 2, 3 are dispatched on consecutive cycles.
6. Reset mid-job:
   - Stimulus: rst low mid-RUN, then start.
   - Response: all outputs return to 0 asynchronously. After rst releases and start pulses, dispatch restarts at from=0.

Source files
------------

// File: rtl/crack_job_scheduler_if.sv
// Host-side job control and engine-pool signals of the crack job scheduler.
// The scheduler takes the master side; the host/engine pool takes the slave side.
interface crack_job_scheduler_if #(
  parameter int NUM_ENGINES = 4,
  parameter int PW_W        = 32
);
  logic                             start;
  logic [PW_W-1:0]                  password_to_crack;
  logic [PW_W-1:0]                  target_pw;
  logic [NUM_ENGINES-1:0]           eng_start;
  logic [NUM_ENGINES-1:0][5:0]      eng_from;
  logic [NUM_ENGINES-1:0][5:0]      eng_to;
  logic                             eng_kill;
  logic [NUM_ENGINES-1:0]           eng_done;
  logic [NUM_ENGINES-1:0]           eng_found;
  logic [NUM_ENGINES-1:0][PW_W-1:0] eng_result;
  logic                             busy;
  logic                             found;
  logic                             done;
  logic [PW_W-1:0]                  cracked_pw;
  logic [5:0]                       chunks_issued;

  modport master (
    input  start, password_to_crack, eng_done, eng_found, eng_result,
    output target_pw, eng_start, eng_from, eng_to, eng_kill,
           busy, found, done, cracked_pw, chunks_issued
  );

  modport slave (
    output start, password_to_crack, eng_done, eng_found, eng_result,
    input  target_pw, eng_start, eng_from, eng_to, eng_kill,
           busy, found, done, cracked_pw, chunks_issued
  );
endinterface

// File: rtl/crack_job_scheduler.sv
// Hands CHUNK-wide first-character ranges to free engines, latches the first hit,
// aborts the pool on a hit and reports exhaustion when every range came back empty.
module crack_job_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int CHARSET     = 36,
  parameter int CHUNK       = 4,
  parameter int PW_W        = 32
) (
  input logic                   clk,
  input logic                   rst,
  crack_job_scheduler_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_KILL, S_DONE} state_e;

  localparam logic [6:0] CS    = 7'(CHARSET);
  localparam logic [6:0] CK    = 7'(CHUNK);
  localparam logic [5:0] CS_M1 = 6'(CHARSET - 1);

  state_e                           state_q, state_d;
  logic [6:0]                       next_from_q, next_from_d;
  logic [NUM_ENGINES-1:0]           idle_q, idle_d;
  logic [PW_W-1:0]                  target_q, target_d;
  logic [PW_W-1:0]                  cracked_q, cracked_d;
  logic                             busy_q, busy_d;
  logic                             found_q, found_d;
  logic                             done_q, done_d;
  logic [5:0]                       chunks_q, chunks_d;
  logic [NUM_ENGINES-1:0][5:0]      from_q, from_d;
  logic [NUM_ENGINES-1:0][5:0]      to_q, to_d;

  logic [NUM_ENGINES-1:0]           sel;
  logic [NUM_ENGINES-1:0]           hit_vec;
  logic                             hit;
  logic [PW_W-1:0]                  hit_pw;
  logic [6:0]                       end_raw;
  logic [5:0]                       to_calc;

  // Hit arbitration and dispatch choice; reports from idle engines never count.
  always_comb begin
    hit_vec = bus.eng_done & bus.eng_found & ~idle_q;
    hit     = (state_q == S_RUN) && (hit_vec != '0);
    hit_pw  = '0;
    for (int j = NUM_ENGINES - 1; j >= 0; j--)
      if (hit_vec[j]) hit_pw = bus.eng_result[j];
    sel = '0;
    if (state_q == S_RUN && !hit && next_from_q < CS)
      for (int i = NUM_ENGINES - 1; i >= 0; i--)
        if (idle_q[i]) begin
          sel    = '0;
          sel[i] = 1'b1;
        end
    end_raw = next_from_q + CK - 7'd1;
    to_calc = (end_raw >= CS) ? CS_M1 : end_raw[5:0];
  end

  always_comb begin
    state_d     = state_q;
    next_from_d = next_from_q;
    idle_d      = idle_q;
    target_d    = target_q;
    cracked_d   = cracked_q;
    busy_d      = busy_q;
    found_d     = found_q;
    done_d      = done_q;
    chunks_d    = chunks_q;
    from_d      = from_q;
    to_d        = to_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d     = S_RUN;
          target_d    = bus.password_to_crack;
          cracked_d   = '0;
          found_d     = 1'b0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
          chunks_d    = '0;
          next_from_d = '0;
          idle_d      = '1;
        end
      end
      S_RUN: begin
        if (hit) begin
          state_d   = S_KILL;
          cracked_d = hit_pw;
          found_d   = 1'b1;
        end else if (next_from_q >= CS && idle_q == '1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          // A completing engine only becomes eligible from the next cycle on.
          idle_d = (idle_q | bus.eng_done) & ~sel;
          if (sel != '0) begin
            next_from_d = next_from_q + CK;
            chunks_d    = chunks_q + 6'd1;
            for (int i = 0; i < NUM_ENGINES; i++)
              if (sel[i]) begin
                from_d[i] = next_from_q[5:0];
                to_d[i]   = to_calc;
              end
          end
        end
      end
      S_KILL: begin
        state_d = S_DONE;
        idle_d  = '1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      next_from_q <= '0;
      idle_q      <= '1;
      target_q    <= '0;
      cracked_q   <= '0;
      busy_q      <= 1'b0;
      found_q     <= 1'b0;
      done_q      <= 1'b0;
      chunks_q    <= '0;
      from_q      <= '0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      next_from_q <= next_from_d;
      idle_q      <= idle_d;
      target_q    <= target_d;
      cracked_q   <= cracked_d;
      busy_q      <= busy_d;
      found_q     <= found_d;
      done_q      <= done_d;
      chunks_q    <= chunks_d;
      from_q      <= from_d;
      to_q        <= to_d;
    end
  end

  // Range outputs show the new range in the load cycle and hold it afterwards.
  always_comb begin
    for (int i = 0; i < NUM_ENGINES; i++) begin
      bus.eng_from[i] = sel[i] ? next_from_q[5:0] : from_q[i];
      bus.eng_to[i]   = sel[i] ? to_calc : to_q[i];
    end
  end

  assign bus.eng_start     = sel;
  assign bus.eng_kill      = (state_q == S_KILL);
  assign bus.target_pw     = target_q;
  assign bus.busy          = busy_q;
  assign bus.found         = found_q;
  assign bus.done          = done_q;
  assign bus.cracked_pw    = cracked_q;
  assign bus.chunks_issued = chunks_q;
endmodule
